// File: rtl/otter_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : otter_control_unit
// Description : OTTER RV32I multi-cycle control FSM with combinational decode
//               of the current instruction into ALU, mux and strobe controls.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_control_unit #(
    parameter int INIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ir,
    input  logic        intr,
    input  logic        csr_mie,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic        pcWrite,
    output logic        regWrite,
    output logic        memWE2,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        reset,
    output logic        csr_WE,
    output logic        int_taken,
    output logic        mret_exec,
    output logic [3:0]  alu_fun,
    output logic        srcA_sel,
    output logic [2:0]  srcB_sel,
    output logic [2:0]  pcSource,
    output logic [1:0]  rf_wr_sel
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [3:0] c_INIT_LAST = 4'(INIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_init_cnt;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_f7b5;
    logic        w_irq;
    logic        w_br_taken;
    logic        w_unused;

    assign w_opcode = ir[6:0];
    assign w_funct3 = ir[14:12];
    assign w_f7b5   = ir[30];
    assign w_irq    = intr & csr_mie;
    assign w_unused = ^{ir[19:15], ir[11:7]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INIT)
                r_init_cnt <= r_init_cnt + 4'd1;
        end
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_br_taken = br_eq;
            3'b001:  w_br_taken = ~br_eq;
            3'b100:  w_br_taken = br_lt;
            3'b101:  w_br_taken = ~br_lt;
            3'b110:  w_br_taken = br_ltu;
            3'b111:  w_br_taken = ~br_ltu;
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        alu_fun   = 4'b0000;
        srcA_sel  = 1'b0;
        srcB_sel  = 3'd0;
        pcSource  = 3'd0;
        rf_wr_sel = 2'd0;

        case (r_state)
            ST_INIT: begin
                reset = 1'b1;
                if (r_init_cnt >= c_INIT_LAST)
                    w_next = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1 = 1'b1;
                w_next   = ST_EXEC;
            end
            ST_EXEC: begin
                pcWrite = 1'b1;
                w_next  = w_irq ? ST_INTR : ST_FETCH;
                case (w_opcode)
                    c_OP_OP: begin
                        alu_fun   = {w_f7b5, w_funct3};
                        rf_wr_sel = 2'd3;
                        regWrite  = 1'b1;
                    end
                    c_OP_IMM: begin
                        // bit 30 only selects arithmetic shift; for other ops it is immediate data
                        alu_fun   = {w_f7b5 & (w_funct3 == 3'b101), w_funct3};
                        srcB_sel  = 3'd1;
                        rf_wr_sel = 2'd3;
                        regWrite  = 1'b1;
                    end
                    c_OP_LUI: begin
                        alu_fun   = 4'b1001;
                        srcA_sel  = 1'b1;
                        rf_wr_sel = 2'd3;
                        regWrite  = 1'b1;
                    end
                    c_OP_AUIPC: begin
                        srcA_sel  = 1'b1;
                        srcB_sel  = 3'd3;
                        rf_wr_sel = 2'd3;
                        regWrite  = 1'b1;
                    end
                    c_OP_JAL: begin
                        pcSource = 3'd3;
                        regWrite = 1'b1;
                    end
                    c_OP_JALR: begin
                        pcSource = 3'd1;
                        regWrite = 1'b1;
                    end
                    c_OP_LOAD: begin
                        pcWrite  = 1'b0;
                        srcB_sel = 3'd1;
                        memRDEN2 = 1'b1;
                        w_next   = ST_WB;
                    end
                    c_OP_STORE: begin
                        srcB_sel = 3'd2;
                        memWE2   = 1'b1;
                    end
                    c_OP_BRANCH: begin
                        pcSource = w_br_taken ? 3'd2 : 3'd0;
                    end
                    c_OP_SYSTEM: begin
                        if (w_funct3 == 3'b001) begin
                            csr_WE    = 1'b1;
                            regWrite  = 1'b1;
                            rf_wr_sel = 2'd1;
                            alu_fun   = 4'b1001;
                        end else if (w_funct3 == 3'b000 && ir[31:20] == 12'h302) begin
                            mret_exec = 1'b1;
                            pcSource  = 3'd5;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                regWrite  = 1'b1;
                rf_wr_sel = 2'd2;
                pcWrite   = 1'b1;
                srcB_sel  = 3'd1;
                w_next    = w_irq ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pcWrite   = 1'b1;
                pcSource  = 3'd4;
                w_next    = ST_FETCH;
            end
            default: w_next = ST_INIT;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_control_unit
// Description : Table-driven, scoreboard-checked bench for otter_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_control_unit;

    typedef struct packed {
        logic       pcw, rw, we2, rd1, rd2, rst, csrwe, it, mret;
        logic [3:0] alu;
        logic       a;
        logic [2:0] b;
        logic [2:0] pcs;
        logic [1:0] rf;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        logic        intr, mie, eq, lt, ltu;
        ctl_t        exec;
        bit          wb;
        bit          irq;
    } vec_t;

    typedef struct {
        ctl_t  exp;
        string name;
    } sb_t;

    localparam logic [8:0] S_PCW  = 9'h100;
    localparam logic [8:0] S_RW   = 9'h080;
    localparam logic [8:0] S_WE2  = 9'h040;
    localparam logic [8:0] S_RD1  = 9'h020;
    localparam logic [8:0] S_RD2  = 9'h010;
    localparam logic [8:0] S_RST  = 9'h008;
    localparam logic [8:0] S_CSR  = 9'h004;
    localparam logic [8:0] S_IT   = 9'h002;
    localparam logic [8:0] S_MRET = 9'h001;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        intr = 1'b0, csr_mie = 1'b0, br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
    logic        pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec;
    logic [3:0]  alu_fun;
    logic        srcA_sel;
    logic [2:0]  srcB_sel, pcSource;
    logic [1:0]  rf_wr_sel;
    ctl_t        act;

    int tests = 0;
    int fails = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    otter_control_unit #(.INIT_CYCLES(1)) dut (
        .CLK(CLK), .RST(RST), .ir(ir), .intr(intr), .csr_mie(csr_mie),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2),
        .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .reset(reset),
        .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec),
        .alu_fun(alu_fun), .srcA_sel(srcA_sel), .srcB_sel(srcB_sel),
        .pcSource(pcSource), .rf_wr_sel(rf_wr_sel)
    );

    always #5 CLK = ~CLK;

    assign act = {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE,
                  int_taken, mret_exec, alu_fun, srcA_sel, srcB_sel, pcSource, rf_wr_sel};

    function automatic ctl_t mk(input logic [8:0] s, input logic [3:0] alu, input logic a,
                                input logic [2:0] b, input logic [2:0] pcs, input logic [1:0] rf);
        return {s, alu, a, b, pcs, rf};
    endfunction

    function automatic vec_t v(input logic [31:0] i, input logic [4:0] in, input ctl_t e,
                               input bit wb, input bit irq);
        vec_t r;
        r.ir = i; r.intr = in[4]; r.mie = in[3]; r.eq = in[2]; r.lt = in[1]; r.ltu = in[0];
        r.exec = e; r.wb = wb; r.irq = irq;
        return r;
    endfunction

    // Called #1 after a rising edge; checks outputs #1 later, returns #1 after the next edge.
    task automatic cyc(input ctl_t exp, input string name);
        sb_t e;
        sb.push_back('{exp, name});
        #1;
        e = sb.pop_front();
        tests++;
        if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    ctl_t c_init, c_fetch, c_wb, c_intr, c_add, c_lw, c_sw;

    initial begin
        c_init  = mk(S_RST, 4'b0000, 1'b0, 3'd0, 3'd0, 2'd0);
        c_fetch = mk(S_RD1, 4'b0000, 1'b0, 3'd0, 3'd0, 2'd0);
        c_wb    = mk(S_PCW | S_RW, 4'b0000, 1'b0, 3'd1, 3'd0, 2'd2);
        c_intr  = mk(S_PCW | S_IT, 4'b0000, 1'b0, 3'd0, 3'd4, 2'd0);
        c_add   = mk(S_PCW | S_RW, 4'b0000, 1'b0, 3'd0, 3'd0, 2'd3);
        c_lw    = mk(S_RD2, 4'b0000, 1'b0, 3'd1, 3'd0, 2'd0);
        c_sw    = mk(S_PCW | S_WE2, 4'b0000, 1'b0, 3'd2, 3'd0, 2'd0);

        // inputs {intr, mie, eq, lt, ltu}
        tbl.push_back(v(32'h40208033, 5'b00000, mk(S_PCW|S_RW, 4'b1000, 0, 3'd0, 3'd0, 2'd3), 0, 0)); // sub
        tbl.push_back(v(32'h00208033, 5'b00000, c_add, 0, 0));                                          // add
        tbl.push_back(v(32'h4020D093, 5'b00000, mk(S_PCW|S_RW, 4'b1101, 0, 3'd1, 3'd0, 2'd3), 0, 0)); // srai
        tbl.push_back(v(32'h0020D093, 5'b00000, mk(S_PCW|S_RW, 4'b0101, 0, 3'd1, 3'd0, 2'd3), 0, 0)); // srli
        tbl.push_back(v(32'h40008093, 5'b00000, mk(S_PCW|S_RW, 4'b0000, 0, 3'd1, 3'd0, 2'd3), 0, 0)); // addi, b30 set
        tbl.push_back(v(32'h123450B7, 5'b00000, mk(S_PCW|S_RW, 4'b1001, 1, 3'd0, 3'd0, 2'd3), 0, 0)); // lui
        tbl.push_back(v(32'h00000097, 5'b00000, mk(S_PCW|S_RW, 4'b0000, 1, 3'd3, 3'd0, 2'd3), 0, 0)); // auipc
        tbl.push_back(v(32'h008000EF, 5'b00000, mk(S_PCW|S_RW, 4'b0000, 0, 3'd0, 3'd3, 2'd0), 0, 0)); // jal
        tbl.push_back(v(32'h000080E7, 5'b00000, mk(S_PCW|S_RW, 4'b0000, 0, 3'd0, 3'd1, 2'd0), 0, 0)); // jalr
        tbl.push_back(v(32'h0000A083, 5'b00000, c_lw, 1, 0));                                           // lw
        tbl.push_back(v(32'h0020A023, 5'b00000, c_sw, 0, 0));                                           // sw
        tbl.push_back(v(32'h00208463, 5'b00100, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd2, 2'd0), 0, 0));      // beq taken
        tbl.push_back(v(32'h00208463, 5'b00011, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd0, 2'd0), 0, 0));      // beq not taken
        tbl.push_back(v(32'h0020B463, 5'b00111, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd0, 2'd0), 0, 0));      // funct3 011
        tbl.push_back(v(32'h00209463, 5'b00000, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd2, 2'd0), 0, 0));      // bne taken
        tbl.push_back(v(32'h0020C463, 5'b00010, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd2, 2'd0), 0, 0));      // blt taken
        tbl.push_back(v(32'h0020D463, 5'b00010, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd0, 2'd0), 0, 0));      // bge not taken
        tbl.push_back(v(32'h0020E463, 5'b00001, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd2, 2'd0), 0, 0));      // bltu taken
        tbl.push_back(v(32'h0020F463, 5'b00000, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd2, 2'd0), 0, 0));      // bgeu taken
        tbl.push_back(v(32'h30009073, 5'b00000, mk(S_PCW|S_RW|S_CSR, 4'b1001, 0, 3'd0, 3'd0, 2'd1), 0, 0)); // csrrw
        tbl.push_back(v(32'h30200073, 5'b00000, mk(S_PCW|S_MRET, 4'b0000, 0, 3'd0, 3'd5, 2'd0), 0, 0)); // mret
        tbl.push_back(v(32'h00000073, 5'b00000, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd0, 2'd0), 0, 0));      // ecall nop
        tbl.push_back(v(32'h0000007F, 5'b00000, mk(S_PCW, 4'b0000, 0, 3'd0, 3'd0, 2'd0), 0, 0));      // bad opcode
        tbl.push_back(v(32'h00208033, 5'b11000, c_add, 0, 1));                                          // add + irq
        tbl.push_back(v(32'h00208033, 5'b10000, c_add, 0, 0));                                          // irq masked
        tbl.push_back(v(32'h0020A023, 5'b11000, c_sw, 0, 1));                                           // sw + irq
        tbl.push_back(v(32'h0000A083, 5'b11000, c_lw, 1, 1));                                           // lw + irq

        @(posedge CLK);
        #1;
        cyc(c_init, "rst_hold");
        RST = 1'b0;
        cyc(c_init, "init");

        for (int i = 0; i < tbl.size(); i++) begin
            ir = tbl[i].ir; intr = tbl[i].intr; csr_mie = tbl[i].mie;
            br_eq = tbl[i].eq; br_lt = tbl[i].lt; br_ltu = tbl[i].ltu;
            cyc(c_fetch, $sformatf("fetch%0d", i));
            cyc(tbl[i].exec, $sformatf("exec%0d", i));
            if (tbl[i].wb)  cyc(c_wb, $sformatf("wb%0d", i));
            if (tbl[i].irq) cyc(c_intr, $sformatf("intr%0d", i));
        end

        // interrupt pulse confined to FETCH must be ignored
        ir = 32'h00208033; intr = 1'b1; csr_mie = 1'b1;
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        cyc(c_fetch, "pulse_fetch");
        intr = 1'b0;
        cyc(c_add, "pulse_exec");
        cyc(c_fetch, "pulse_no_intr");
        cyc(c_add, "pulse_exec2");

        // reset asserted during WB aborts to INIT
        ir = 32'h0000A083;
        cyc(c_fetch, "rstwb_fetch");
        cyc(c_lw, "rstwb_exec");
        RST = 1'b1;
        cyc(c_wb, "rstwb_wb");
        RST = 1'b0;
        cyc(c_init, "rstwb_init");
        cyc(c_fetch, "rstwb_refetch");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otter_control_unit.md
Name: otter_control_unit

Overview:
- Control unit for the 32-bit OTTER RV32I MCU: multi-cycle FSM plus instruction decoder.
- Sits opposite the ALU. It generates alu_fun, the operand-mux selects and every write/read strobe, so the ALU, register file, PC and memory execute each instruction.
- Decode is combinational from IR and the current state; sequencing is a registered FSM.

Parameters:
- INIT_CYCLES, 1, number of cycles held in INIT after reset (reset output asserted); legal range 1-15.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- ir  in  32  current instruction; opcode=ir[6:0], funct3=ir[14:12], funct7b5=ir[30]
- intr  in  1  external interrupt request, level
- csr_mie  in  1  interrupt enable from CSR file
- br_eq, br_lt, br_ltu  in  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
- pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec  out  1 each  strobes
- alu_fun  out  4  ALU op code
- srcA_sel  out  1  0=rs1, 1=U-imm
- srcB_sel  out  3  0=rs2, 1=I-imm, 2=S-imm, 3=PC, 4=CSR read
- pcSource  out  3  0=PC+4, 1=jalr, 2=branch, 3=jal, 4=mtvec, 5=mepc
- rf_wr_sel  out  2  0=PC+4, 1=CSR, 2=mem dout2, 3=ALU

Behaviour:
- States: INIT, FETCH, EXEC, WB, INTR; 3-bit registered state.
- RST=1 at any edge, including mid-instruction: state<=INIT and the INIT counter reloads.
- In INIT: reset=1 and all other outputs 0. After INIT_CYCLES cycles go to FETCH.
- All outputs not named for a state are 0. alu_fun, srcA_sel, srcB_sel, pcSource and rf_wr_sel are 0 outside EXEC/WB/INTR.
- FETCH: memRDEN1=1; next state EXEC.
- EXEC: decode ir. pcWrite=1 unless opcode=LOAD.
  - If LOAD: memRDEN2=1, next state WB.
  - Otherwise: if intr&csr_mie then INTR, else FETCH.
- WB: regWrite=1, rf_wr_sel=2, pcWrite=1, pcSource=0, alu_fun=0000, srcB_sel=1. Next state: INTR if intr&csr_mie, else FETCH.
- INTR: int_taken=1, pcWrite=1, pcSource=4; next state FETCH. intr is sampled only at the end of EXEC/WB; a pulse in FETCH is ignored unless still high at that point.
- Decode in EXEC:
  - OP (0110011): alu_fun={funct7b5,funct3}, srcA=0, srcB=0, rf_wr_sel=3, regWrite=1.
  - OP-IMM (0010011): alu_fun={funct7b5&(funct3==101),funct3}, srcB=1, rf_wr_sel=3, regWrite=1.
  - LUI (0110111): alu_fun=1001, srcA=1, rf_wr_sel=3, regWrite=1.
  - AUIPC (0010111): alu_fun=0000, srcA=1, srcB=3, rf_wr_sel=3, regWrite=1.
  - JAL (1101111): pcSource=3, rf_wr_sel=0, regWrite=1.
  - JALR (1100111): pcSource=1, rf_wr_sel=0, regWrite=1.
  - LOAD (0000011): alu_fun=0000, srcB=1. Register write happens in WB.
  - STORE (0100011): alu_fun=0000, srcB=2, memWE2=1.
  - BRANCH (1100011): pcSource=2 if taken, else 0. Taken by funct3: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never.
  - SYSTEM (1110011):
    - funct3=001 (csrrw): csr_WE=1, regWrite=1, rf_wr_sel=1, alu_fun=1001 (srcA=rs1 pass).
    - funct3=000 and ir[31:20]=0x302 (mret): mret_exec=1, pcSource=5.
    - Other SYSTEM: NOP.
  - Any other opcode: NOP. pcWrite=1, pcSource=0, no writes, alu_fun=0000.
- An interrupt taken after a store or branch still commits that instruction's strobes in EXEC first.

Test Plan:
- RST high 2 cycles, then release with INIT_CYCLES=1 -> reset=1 during INIT only; memRDEN1=1 on the following cycle (FETCH).
- ir=0x40208033 (sub x0,x1,x2) in EXEC -> alu_fun=1000, srcB_sel=0, regWrite=1, rf_wr_sel=3, pcWrite=1; then FETCH.
- ir=0x4020D093 (srai) -> alu_fun=1101. ir=0x0020D093 (srli) -> alu_fun=0101.
- ir=0x0000A083 (lw) -> sequence FETCH/EXEC(memRDEN2=1, pcWrite=0)/WB(regWrite=1, rf_wr_sel=2, pcWrite=1), 3 cycles.
- ir=0x00208463 (beq): br_eq=1 -> pcSource=2; br_eq=0 -> pcSource=0; ir=0x0020B463 (funct3=011) -> pcSource=0 regardless of flags.
- intr=1, csr_mie=1 during EXEC of add -> regWrite in EXEC, then INTR cycle (int_taken=1, pcSource=4), then FETCH.
- intr=1, csr_mie=0 -> no INTR state.
- RST asserted in WB -> next state INIT, regWrite=0.
